mem_io_responder: RTL and testbench
===================================

Name: mem_io_responder

Overview:
- Memory and I/O responder on the far side of the multicycle control FSM's memory interface.
- Serves word reads/writes from a parameterised internal RAM and a small memory-mapped I/O window.
- Flags access-invalid and misaligned requests in the same cycle so the FSM can branch into its exception handler.
- Owns the input-device buffer that raises InputRecv and accepts InputRst.

Parameters:
DEPTH, 1024, RAM size in 16-bit words (power of two)
KBASE, 16'hE000, first byte address of kernel-only region (up to 16'hFEFF)
READ_LAT, 2, cycles from read acceptance to Ready/RData valid (>=1)

Ports:
CLK  input  1  clock, rising edge
Reset  input  1  asynchronous, active-low reset
Req  input  1  access request, one cycle
We  input  1  1=write, 0=read (valid with Req)
Kernel  input  1  requester in kernel mode
Addr  input  16  byte address
WData  input  16  write data
RData  output  16  read data
Ready  output  1  one-cycle completion pulse
AccInv  output  1  access invalid (combinational)
Misalign  output  1  misaligned access (combinational)
DevInData  input  16  input device data
DevInValid  input  1  input device offers data
DevInAck  output  1  one-cycle capture acknowledge
DevOutData  output  16  output device data
DevOutValid  output  1  output data pending
DevOutReady  input  1  output device consumes data
InputRecv  output  1  input interrupt pending
InputRst  input  1  clear InputRecv

Behaviour:
- Reset low → state IDLE; RData=0, Ready=0, DevInAck=0, DevOutData=0, DevOutValid=0, InputRecv=0; in-buffer empty; overrun bit=0. RAM contents not reset.
- Address map:
  - below KBASE: RAM, user and kernel.
  - KBASE..16'hFEFF: RAM, kernel only.
  - 16'hFF00: input data (R).
  - 16'hFF02: status (R) — bit0 in-full, bit1 out-busy, bit2 out-overrun.
  - 16'hFF04: output data (W).
  - Other FFxx: invalid.
- RAM word index = Addr[15:1] mod DEPTH.
- AccInv = Req & state==IDLE & (kernel region & !Kernel | invalid FFxx | write to FF00/FF02 | read of FF04).
- Misalign = Req & state==IDLE & Addr[0] & !AccInv. AccInv has priority.
- Either flag set: request dropped, no state change, no RAM/IO side effect, no Ready.
- FSM states IDLE, RWAIT, DONE:
  - IDLE + valid write: commit at that edge; go to DONE. Ready=1 in the next cycle.
  - IDLE + valid read: load counter with READ_LAT-1; go to RWAIT (go straight to DONE if READ_LAT=1). Data is sampled at acceptance.
  - RWAIT: decrement the counter; at 0 go to DONE.
  - DONE: Ready=1, RData holds the read value; next cycle IDLE.
  - Read completion: Ready and new RData appear exactly READ_LAT cycles after the accept edge. RData holds until the next read completes.
  - Req outside IDLE is ignored; AccInv/Misalign stay 0.
- Input buffer:
  - DevInValid & buffer empty → capture DevInData, DevInAck=1 for one cycle, set full and InputRecv.
  - Accepted read of FF00 clears full. If capture is also eligible that cycle, the read wins: old data is returned and capture occurs the next cycle.
  - InputRst clears InputRecv only, not the data or the full flag.
  - A new capture and InputRst in the same cycle leave InputRecv=1.
- Output:
  - Accepted write of FF04 with DevOutValid=0 → DevOutData=WData, DevOutValid=1.
  - Write while DevOutValid=1 → data dropped, overrun=1.
  - DevOutValid & DevOutReady → DevOutValid=0.
  - A write in the same cycle as consumption is treated as busy (overrun).
  - Status read returns the flags, then clears overrun.
- Reset asserted mid-read: read aborted, no Ready.

Optional Feature:
- Macro MEMIO_BOUNDS_EN.
- When defined: any RAM address with Addr[15:1] >= DEPTH asserts AccInv (user or kernel).
- When undefined: indices wrap modulo DEPTH, never flagged.

Test Plan:
- Write 16'hBEEF to 16'h0010; read 16'h0010 with READ_LAT=2 → Ready pulses 1 cycle after the write accept; read Ready and RData=16'hBEEF exactly 2 cycles after accept.
- Read 16'h0011 → Misalign=1 same cycle, no Ready. Kernel=0 read of 16'hE000 → AccInv=1, Misalign=0. Kernel=1 read of 16'hE000 → Ready after 2 cycles.
- DevInValid with DevInData=16'h1234 → DevInAck pulse, InputRecv=1, status bit0=1.
  - Second DevInValid → no ack.
  - InputRst → InputRecv=0, status still 1.
  - Read FF00 → 16'h1234; status bit0=0; pending device data then captured.
- Write FF04=16'h00AA while DevOutReady=0 → DevOutValid=1. Write FF04=16'h00BB → DevOutData stays 16'h00AA; status=3'b110. Status read again → overrun cleared.
- Assert Reset low during RWAIT → all outputs 0 asynchronously; no Ready after release.
- With MEMIO_BOUNDS_EN, DEPTH=1024, read 16'h0800 → AccInv=1. Without the macro → data of 16'h0000 returned.

Source files
------------

// File: rtl/mem_io_responder_if.sv
// Memory-side bus between the multicycle control FSM and mem_io_responder.
// master = control FSM, slave = responder.
interface mem_io_responder_if;
    logic        Req;
    logic        We;
    logic        Kernel;
    logic [15:0] Addr;
    logic [15:0] WData;
    logic [15:0] RData;
    logic        Ready;
    logic        AccInv;
    logic        Misalign;
    logic        InputRecv;
    logic        InputRst;

    modport master (
        output Req, We, Kernel, Addr, WData, InputRst,
        input  RData, Ready, AccInv, Misalign, InputRecv
    );

    modport slave (
        input  Req, We, Kernel, Addr, WData, InputRst,
        output RData, Ready, AccInv, Misalign, InputRecv
    );
endinterface

// File: rtl/mem_io_responder.sv
// mem_io_responder: word RAM plus a small memory-mapped I/O window at FFxx.
// Flags invalid/misaligned requests combinationally so the requesting FSM
// can branch the same cycle. Owns the input-device buffer (InputRecv) and a
// one-entry output-device register with an overrun flag.
// Optional build macro MEMIO_BOUNDS_EN: RAM word indices at or beyond DEPTH
// raise AccInv instead of wrapping modulo DEPTH.
module mem_io_responder #(
    parameter int unsigned DEPTH    = 1024,
    parameter logic [15:0] KBASE    = 16'hE000,
    parameter int unsigned READ_LAT = 2
) (
    input  logic               CLK,
    input  logic               Reset,
    mem_io_responder_if.slave  bus,
    input  logic [15:0]        DevInData,
    input  logic               DevInValid,
    output logic               DevInAck,
    output logic [15:0]        DevOutData,
    output logic               DevOutValid,
    input  logic               DevOutReady
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(READ_LAT - 1);

    typedef enum logic [1:0] {IDLE, RWAIT, DONE} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    // Address decode
    logic          is_io;
    logic          sel_ram;
    logic          sel_in;
    logic          sel_stat;
    logic          sel_out;
    logic          kern_region;
    logic          bad_io;
    logic          dir_bad;
    logic          oob;
    logic          invalid;
    logic          idle;
    logic          accept;
    logic          rd_accept;
    logic          wr_accept;
    logic          rd_in;
    logic          rd_stat;
    logic          wr_out;
    logic [AW-1:0] idx;

    // Device-side state
    logic          in_full_reg;
    logic [15:0]   in_data_reg;
    logic          in_ack_reg;
    logic          input_recv_reg;
    logic          capture;
    logic [15:0]   out_data_reg;
    logic          out_valid_reg;
    logic          overrun_reg;
    logic [15:0]   status_word;
    logic [15:0]   io_rd_value;

    logic [15:0]   rdata_reg;
    logic [15:0]   ram [DEPTH];

    assign is_io       = (bus.Addr[15:8] == 8'hFF);
    assign sel_ram     = !is_io;
    // I/O registers are decoded on the word address; an odd byte address
    // inside a register word is reported as misaligned, not invalid.
    assign sel_in      = (bus.Addr[15:1] == 15'h7F80);   // FF00
    assign sel_stat    = (bus.Addr[15:1] == 15'h7F81);   // FF02
    assign sel_out     = (bus.Addr[15:1] == 15'h7F82);   // FF04
    assign kern_region = sel_ram && (bus.Addr >= KBASE);
    assign bad_io      = is_io && !(sel_in || sel_stat || sel_out);
    assign dir_bad     = (bus.We && (sel_in || sel_stat)) || (!bus.We && sel_out);

`ifdef MEMIO_BOUNDS_EN
    assign oob = sel_ram && ({17'd0, bus.Addr[15:1]} >= DEPTH);
`else
    assign oob = 1'b0;
`endif

    assign invalid   = (kern_region && !bus.Kernel) || bad_io || dir_bad || oob;
    assign idle      = (state_reg == IDLE);

    // AccInv outranks Misalign; either one drops the request entirely.
    assign bus.AccInv   = bus.Req && idle && invalid;
    assign bus.Misalign = bus.Req && idle && bus.Addr[0] && !invalid;

    assign accept    = bus.Req && idle && !invalid && !bus.Addr[0];
    assign rd_accept = accept && !bus.We;
    assign wr_accept = accept && bus.We;
    assign rd_in     = rd_accept && sel_in;
    assign rd_stat   = rd_accept && sel_stat;
    assign wr_out    = wr_accept && sel_out;

    assign idx       = bus.Addr[AW:1];

    assign status_word = {13'd0, overrun_reg, out_valid_reg, in_full_reg};
    assign io_rd_value = sel_in ? in_data_reg : status_word;

    // A read of the input buffer takes priority over a capture in the same cycle.
    assign capture = DevInValid && !in_full_reg && !rd_in;

    // FSM state and latency counter
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state: writes finish in one step, reads wait READ_LAT-1 further edges
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (bus.We || (READ_LAT == 1)) begin
                        state_next = DONE;
                    end else begin
                        state_next = RWAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            RWAIT: begin
                cnt_next = cnt_reg - CW'(1);
                if (cnt_next == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.Ready = (state_reg == DONE);
    assign bus.RData = rdata_reg;

    // RAM write port; commits at the accept edge
    always_ff @(posedge CLK) begin
        if (wr_accept && sel_ram) begin
            ram[idx] <= bus.WData;
        end
    end

    generate
        if (READ_LAT == 1) begin : g_lat1
            // Completion coincides with acceptance, so the result register
            // is loaded straight from the RAM / I/O mux.
            always_ff @(posedge CLK or negedge Reset) begin
                if (!Reset) begin
                    rdata_reg <= '0;
                end else if (rd_accept) begin
                    rdata_reg <= sel_ram ? ram[idx] : io_rd_value;
                end
            end
        end else begin : g_latn
            logic [15:0] ram_q;
            logic        src_io_reg;
            logic [15:0] io_q_reg;

            // Registered RAM read, sampled at acceptance
            always_ff @(posedge CLK) begin
                if (rd_accept) begin
                    ram_q <= ram[idx];
                end
            end

            // I/O read value and source select, sampled at acceptance
            always_ff @(posedge CLK or negedge Reset) begin
                if (!Reset) begin
                    src_io_reg <= 1'b0;
                    io_q_reg   <= '0;
                end else if (rd_accept) begin
                    src_io_reg <= is_io;
                    io_q_reg   <= io_rd_value;
                end
            end

            // Publish the sampled value only when the read completes
            always_ff @(posedge CLK or negedge Reset) begin
                if (!Reset) begin
                    rdata_reg <= '0;
                end else if ((state_reg == RWAIT) && (state_next == DONE)) begin
                    rdata_reg <= src_io_reg ? io_q_reg : ram_q;
                end
            end
        end
    endgenerate

    // Input-device buffer, capture acknowledge and interrupt flag
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            in_full_reg    <= 1'b0;
            in_data_reg    <= '0;
            in_ack_reg     <= 1'b0;
            input_recv_reg <= 1'b0;
        end else begin
            in_ack_reg <= capture;
            if (capture) begin
                in_data_reg <= DevInData;
                in_full_reg <= 1'b1;
            end else if (rd_in) begin
                in_full_reg <= 1'b0;
            end
            // A fresh capture beats a simultaneous InputRst.
            if (capture) begin
                input_recv_reg <= 1'b1;
            end else if (bus.InputRst) begin
                input_recv_reg <= 1'b0;
            end
        end
    end

    assign DevInAck      = in_ack_reg;
    assign bus.InputRecv = input_recv_reg;

    // Output-device register; a write while still pending is dropped as overrun
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            if (wr_out && !out_valid_reg) begin
                out_data_reg  <= bus.WData;
                out_valid_reg <= 1'b1;
            end else if (out_valid_reg && DevOutReady) begin
                out_valid_reg <= 1'b0;
            end
            if (wr_out && out_valid_reg) begin
                overrun_reg <= 1'b1;
            end else if (rd_stat) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign DevOutData  = out_data_reg;
    assign DevOutValid = out_valid_reg;

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: a vector table for single
// accesses, hand-written sequences for the device buffers and reset abort,
// and a completion scoreboard checking Ready timing and RData.
module tb_mem_io_responder;
    localparam int unsigned READ_LAT = 2;
`ifdef MEMIO_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] DevInData = '0;
    logic        DevInValid = 1'b0;
    logic        DevInAck;
    logic [15:0] DevOutData;
    logic        DevOutValid;
    logic        DevOutReady = 1'b0;

    mem_io_responder_if bus();

    mem_io_responder #(
        .DEPTH(1024),
        .KBASE(16'hE000),
        .READ_LAT(READ_LAT)
    ) dut (
        .CLK(CLK),
        .Reset(Reset),
        .bus(bus),
        .DevInData(DevInData),
        .DevInValid(DevInValid),
        .DevInAck(DevInAck),
        .DevOutData(DevOutData),
        .DevOutValid(DevOutValid),
        .DevOutReady(DevOutReady)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int ack_count = 0;
    logic [15:0] last_rdata = '0;

    typedef struct {
        logic [15:0] rdata;
        int          due;
        int          tag;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        we;
        logic        kern;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        inv;
        logic        mis;
        logic [15:0] rd;
    } vec_t;
    vec_t vt[21];

    always @(posedge CLK) cycle <= cycle + 1;

    // Completion monitor: every Ready must match the oldest expected entry
    always @(negedge CLK) begin
        exp_t e;
        if (DevInAck) ack_count++;
        if (bus.Ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready: Ready=1 at cycle %0d, required no completion", cycle);
            end else begin
                e = sb.pop_front();
                if (bus.RData !== e.rdata || cycle != e.due) begin
                    errors++;
                    $display("FAIL completion_%0d: RData=%h cycle=%0d, required RData=%h cycle=%0d",
                             e.tag, bus.RData, cycle, e.rdata, e.due);
                end else begin
                    $display("completion_%0d: RData=%h at cycle %0d", e.tag, bus.RData, cycle);
                end
            end
        end else if (sb.size() != 0 && cycle > sb[0].due) begin
            checks++;
            errors++;
            $display("FAIL late_ready_%0d: no Ready by cycle %0d, required at cycle %0d",
                     sb[0].tag, cycle, sb[0].due);
            void'(sb.pop_front());
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Wait (bounded) for outstanding completions, then realign to posedge+1
    task automatic wait_idle(input int tag);
        for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge CLK);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout_%0d: %0d completions outstanding, required 0", tag, sb.size());
            sb.delete();
        end
        repeat (2) @(posedge CLK);
        #1;
    endtask

    // One request; called at posedge+1, returns at posedge+1 with DUT idle
    task automatic access(input int tag, input logic we, input logic kern,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input logic exp_inv, input logic exp_mis, input logic [15:0] exp_rd);
        exp_t e;
        bus.Req = 1'b1;
        bus.We = we;
        bus.Kernel = kern;
        bus.Addr = addr;
        bus.WData = wdata;
        @(negedge CLK);
        check($sformatf("accinv_%0d", tag), 16'(bus.AccInv), 16'(exp_inv));
        check($sformatf("misalign_%0d", tag), 16'(bus.Misalign), 16'(exp_mis));
        @(posedge CLK);
        #1;
        bus.Req = 1'b0;
        $display("access_%0d: we=%0b kern=%0b addr=%h wdata=%h inv=%0b mis=%0b",
                 tag, we, kern, addr, wdata, exp_inv, exp_mis);
        if (!exp_inv && !exp_mis) begin
            if (!we) last_rdata = exp_rd;
            e.rdata = last_rdata;
            e.due = cycle + (we ? 0 : int'(READ_LAT) - 1);
            e.tag = tag;
            sb.push_back(e);
        end
        wait_idle(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack0;
        bus.Req = 1'b0;
        bus.We = 1'b0;
        bus.Kernel = 1'b0;
        bus.Addr = '0;
        bus.WData = '0;
        bus.InputRst = 1'b0;

        //           we    kern  addr      wdata     inv   mis   rd
        vt[0]  = '{1'b1, 1'b0, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 16'h0000};
        vt[1]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'hBEEF};
        vt[2]  = '{1'b0, 1'b0, 16'h0011, 16'h0000, 1'b0, 1'b1, 16'h0000};
        vt[3]  = '{1'b1, 1'b0, 16'h0000, 16'h5A5A, 1'b0, 1'b0, 16'h0000};
        vt[4]  = '{1'b0, 1'b0, 16'hE000, 16'h0000, 1'b1, 1'b0, 16'h0000};
        vt[5]  = '{1'b0, 1'b1, 16'hE000, 16'h0000, 1'b0, 1'b0, 16'h5A5A};
        vt[6]  = '{1'b1, 1'b1, 16'hE100, 16'h1357, 1'b0, 1'b0, 16'h0000};
        vt[7]  = '{1'b0, 1'b1, 16'hE100, 16'h0000, 1'b0, 1'b0, 16'h1357};
        vt[8]  = '{1'b0, 1'b0, 16'hFEFE, 16'h0000, 1'b1, 1'b0, 16'h0000};
        vt[9]  = '{1'b1, 1'b0, 16'hFF00, 16'h1111, 1'b1, 1'b0, 16'h0000};
        vt[10] = '{1'b1, 1'b1, 16'hFF02, 16'h1111, 1'b1, 1'b0, 16'h0000};
        vt[11] = '{1'b0, 1'b1, 16'hFF04, 16'h0000, 1'b1, 1'b0, 16'h0000};
        vt[12] = '{1'b0, 1'b1, 16'hFF06, 16'h0000, 1'b1, 1'b0, 16'h0000};
        vt[13] = '{1'b0, 1'b0, 16'hFFF0, 16'h0000, 1'b1, 1'b0, 16'h0000};
        vt[14] = '{1'b0, 1'b0, 16'h0800, 16'h0000, 1'b0, 1'b0, 16'h5A5A};
        vt[15] = '{1'b1, 1'b0, 16'hDFFE, 16'hCAFE, 1'b0, 1'b0, 16'h0000};
        vt[16] = '{1'b0, 1'b0, 16'hDFFE, 16'h0000, 1'b0, 1'b0, 16'hCAFE};
        vt[17] = '{1'b1, 1'b0, 16'h0012, 16'h2222, 1'b0, 1'b0, 16'h0000};
        vt[18] = '{1'b1, 1'b0, 16'h0013, 16'hFFFF, 1'b0, 1'b1, 16'h0000};
        vt[19] = '{1'b0, 1'b0, 16'h0012, 16'h0000, 1'b0, 1'b0, 16'h2222};
        vt[20] = '{1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'hBEEF};

        // Reset state
        #2;
        check("rst_ready", 16'(bus.Ready), 16'h0);
        check("rst_rdata", bus.RData, 16'h0);
        check("rst_devinack", 16'(DevInAck), 16'h0);
        check("rst_devoutdata", DevOutData, 16'h0);
        check("rst_devoutvalid", 16'(DevOutValid), 16'h0);
        check("rst_inputrecv", 16'(bus.InputRecv), 16'h0);
        repeat (3) @(posedge CLK);
        #1;
        Reset = 1'b1;
        @(posedge CLK);
        #1;

        // Vector table: plain accesses, address map, flags
        for (int i = 0; i < 21; i++) begin
            vec_t v;
            v = vt[i];
            if (BOUNDS && v.addr >= 16'h0800 && v.addr < 16'hFF00) begin
                v.inv = 1'b1;
                v.mis = 1'b0;
            end
            access(i, v.we, v.kern, v.addr, v.wdata, v.inv, v.mis, v.rd);
        end

        // Input buffer: capture, second offer ignored, InputRst, read-out
        ack0 = ack_count;
        DevInData = 16'h1234;
        DevInValid = 1'b1;
        @(posedge CLK);
        #1;
        DevInData = 16'h5678;
        check("in_ack_pulse", 16'(DevInAck), 16'h1);
        check("in_recv_set", 16'(bus.InputRecv), 16'h1);
        repeat (3) @(posedge CLK);
        #1;
        DevInValid = 1'b0;
        check("in_single_ack", 16'(ack_count - ack0), 16'd1);
        access(100, 1'b0, 1'b0, 16'hFF02, 16'h0, 1'b0, 1'b0, 16'h0001);
        bus.InputRst = 1'b1;
        @(posedge CLK);
        #1;
        bus.InputRst = 1'b0;
        check("in_recv_cleared", 16'(bus.InputRecv), 16'h0);
        access(101, 1'b0, 1'b0, 16'hFF02, 16'h0, 1'b0, 1'b0, 16'h0001);
        access(102, 1'b0, 1'b0, 16'hFF00, 16'h0, 1'b0, 1'b0, 16'h1234);
        access(103, 1'b0, 1'b0, 16'hFF02, 16'h0, 1'b0, 1'b0, 16'h0000);

        // Capture and InputRst in the same cycle: InputRecv stays set
        ack0 = ack_count;
        DevInData = 16'h5678;
        DevInValid = 1'b1;
        bus.InputRst = 1'b1;
        @(posedge CLK);
        #1;
        DevInValid = 1'b0;
        bus.InputRst = 1'b0;
        check("in_recv_vs_rst", 16'(bus.InputRecv), 16'h1);
        @(posedge CLK);
        #1;
        check("in_ack_second", 16'(ack_count - ack0), 16'd1);
        access(104, 1'b0, 1'b0, 16'hFF00, 16'h0, 1'b0, 1'b0, 16'h5678);

        // Read of FF00 beats a simultaneous capture; capture follows
        ack0 = ack_count;
        DevInData = 16'h9ABC;
        DevInValid = 1'b1;
        access(105, 1'b0, 1'b0, 16'hFF00, 16'h0, 1'b0, 1'b0, 16'h5678);
        DevInValid = 1'b0;
        check("in_late_capture", 16'(ack_count - ack0), 16'd1);
        access(106, 1'b0, 1'b0, 16'hFF02, 16'h0, 1'b0, 1'b0, 16'h0001);
        access(107, 1'b0, 1'b0, 16'hFF00, 16'h0, 1'b0, 1'b0, 16'h9ABC);

        // Output register: pending, overrun, status read clears overrun
        DevOutReady = 1'b0;
        access(110, 1'b1, 1'b0, 16'hFF04, 16'h00AA, 1'b0, 1'b0, 16'h0);
        check("out_valid_aa", 16'(DevOutValid), 16'h1);
        check("out_data_aa", DevOutData, 16'h00AA);
        access(111, 1'b1, 1'b0, 16'hFF04, 16'h00BB, 1'b0, 1'b0, 16'h0);
        check("out_data_kept", DevOutData, 16'h00AA);
        access(112, 1'b0, 1'b0, 16'hFF02, 16'h0, 1'b0, 1'b0, 16'h0006);
        access(113, 1'b0, 1'b0, 16'hFF02, 16'h0, 1'b0, 1'b0, 16'h0002);
        DevOutReady = 1'b1;
        @(posedge CLK);
        #1;
        DevOutReady = 1'b0;
        check("out_consumed", 16'(DevOutValid), 16'h0);
        access(114, 1'b1, 1'b0, 16'hFF04, 16'h00CC, 1'b0, 1'b0, 16'h0);
        check("out_data_cc", DevOutData, 16'h00CC);
        // Write in the same cycle as consumption counts as overrun
        DevOutReady = 1'b1;
        access(115, 1'b1, 1'b0, 16'hFF04, 16'h00DD, 1'b0, 1'b0, 16'h0);
        DevOutReady = 1'b0;
        check("out_valid_after_race", 16'(DevOutValid), 16'h0);
        check("out_data_after_race", DevOutData, 16'h00CC);
        access(116, 1'b0, 1'b0, 16'hFF02, 16'h0, 1'b0, 1'b0, 16'h0004);
        access(117, 1'b0, 1'b0, 16'hFF02, 16'h0, 1'b0, 1'b0, 16'h0000);

        // Reset during RWAIT: everything clears asynchronously, no Ready
        access(120, 1'b1, 1'b0, 16'hFF04, 16'h00EE, 1'b0, 1'b0, 16'h0);
        access(121, 1'b0, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'hBEEF);
        bus.Req = 1'b1;
        bus.We = 1'b0;
        bus.Addr = 16'h0010;
        DevInData = 16'h4321;
        DevInValid = 1'b1;
        @(posedge CLK);
        #1;
        bus.Req = 1'b0;
        DevInValid = 1'b0;
        check("pre_rst_ack", 16'(DevInAck), 16'h1);
        #1;
        Reset = 1'b0;
        #1;
        check("arst_ready", 16'(bus.Ready), 16'h0);
        check("arst_rdata", bus.RData, 16'h0);
        check("arst_devinack", 16'(DevInAck), 16'h0);
        check("arst_devoutvalid", 16'(DevOutValid), 16'h0);
        check("arst_devoutdata", DevOutData, 16'h0);
        check("arst_inputrecv", 16'(bus.InputRecv), 16'h0);
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        last_rdata = 16'h0000;
        repeat (5) @(posedge CLK);
        #1;
        access(122, 1'b0, 1'b0, 16'hFF02, 16'h0, 1'b0, 1'b0, 16'h0000);
        access(123, 1'b0, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'hBEEF);

        check("scoreboard_drained", 16'(sb.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
